// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state codes, opcodes,
// datapath select encodings and the control-vector bundle.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_I_WB     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_EXC      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2,
    PC_EXC    = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } src_b_e;

  typedef struct packed {
    logic    mem_read;
    logic    mem_write;
    logic    iord;
    logic    ir_write;
    logic    pc_write;
    logic    pc_write_cond;
    pc_src_e pc_source;
    logic    alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    exc;
  } ctrl_t;

  // States in which the FSM sits on the memory port waiting for mem_ready.
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> datapath control decode. The EXC state decode exists
// only when MC_CTRL_EXC_EN is defined.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Moore decode; only the FETCH writes wait for the memory handshake.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
`ifdef MC_CTRL_EXC_EN
      S_EXC: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_EXC;
        ctrl.exc       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the taylor MIPS core: state register, next-state,
// retire counter. MC_CTRL_EXC_EN adds illegal-opcode and memory-timeout traps.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TO = 15,
  parameter int RET_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [RET_W-1:0] retired,
  output logic             exc
);

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  ctrl_t            dec_ctrl;
  ctrl_t            ctrl;
  logic             timeout;
  logic             retire;
  logic [RET_W-1:0] ret_cnt;

  // The branch decision is taken by the datapath through pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (dec_ctrl)
  );

`ifdef MC_CTRL_EXC_EN
  localparam int WT_W = $clog2(MEM_TO + 1);
  logic [WT_W-1:0] wait_cnt;

  // Counts stalled memory cycles within one state; restarts on any state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (is_wait_state(state) && !mem_ready && (wait_cnt != WT_W'(MEM_TO))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = is_wait_state(state) && (wait_cnt == WT_W'(MEM_TO));
`else
  logic unused_cfg;
  assign unused_cfg = (MEM_TO == 0);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_RTYPE:     state_nxt = S_EXEC_R;
          OP_ADDI:      state_nxt = S_EXEC_I;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
`ifdef MC_CTRL_EXC_EN
          default:      state_nxt = S_EXC;
`else
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_EXEC_R:   state_nxt = S_R_WB;
      S_R_WB:     state_nxt = S_FETCH;
      S_EXEC_I:   state_nxt = S_I_WB;
      S_I_WB:     state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
    if (timeout) state_nxt = S_EXC;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Any arrival in FETCH other than a FETCH stall or exception return ends an instruction.
  assign retire = (state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_EXC);

  always_ff @(posedge clk) begin
    if (rst)         ret_cnt <= '0;
    else if (retire) ret_cnt <= ret_cnt + 1'b1;
  end

  // A timed-out request is withdrawn in its last cycle; reset silences everything.
  always_comb begin
    ctrl = dec_ctrl;
    if (timeout) begin
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.ir_write  = 1'b0;
      ctrl.pc_write  = 1'b0;
    end
    if (rst) ctrl = '0;
  end

  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign iord          = ctrl.iord;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign exc           = ctrl.exc;
  assign retired       = rst ? '0 : ret_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction summaries of the control
// outputs are compared with an instruction-level model. Honours MC_CTRL_EXC_EN.
module tb_mc_ctrl;

  localparam int RW = 4;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  logic          clk, rst, zero, mem_ready;
  logic [5:0]    opcode;
  logic          mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]    pc_source, alu_src_b, alu_op;
  logic          alu_src_a, reg_dst, mem_to_reg, reg_write, exc;
  logic [RW-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;

  typedef struct packed {
    logic [7:0] cycles, fetch, pcinc, dec, imm, funct, sub, rw;
    logic [7:0] rw_mdr, rw_rd, mrd, mwr, brn, jmp, excs, both;
  } stats_t;

  mc_ctrl #(.MEM_TO(15), .RET_W(RW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retired(retired), .exc(exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction

  function automatic logic [5:0] pick_op(input bit legal_only);
    logic [5:0] op;
    int k;
    k = legal_only ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 6));
    case (k)
      0: op = OP_R;
      1: op = OP_LW;
      2: op = OP_SW;
      3: op = OP_BEQ;
      4: op = OP_J;
      5: op = OP_ADDI;
      default: begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  function automatic int retire_of(input logic [5:0] op);
`ifdef MC_CTRL_EXC_EN
    return is_legal(op) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  // Expected per-instruction footprint from the instruction's step list.
  function automatic stats_t expect_stats(input logic [5:0] op, input int fw, input int mw);
    stats_t e;
    e = '0;
    e.fetch = 8'(fw + 1);
    e.pcinc = 8'd1;
    e.dec   = 8'd1;
    case (op)
      OP_LW:   begin e.cycles = 8'(5 + fw + mw); e.imm = 8'd1; e.rw = 8'd1; e.rw_mdr = 8'd1; e.mrd = 8'(1 + mw); end
      OP_SW:   begin e.cycles = 8'(4 + fw + mw); e.imm = 8'd1; e.mwr = 8'(1 + mw); end
      OP_R:    begin e.cycles = 8'(4 + fw); e.funct = 8'd1; e.rw = 8'd1; e.rw_rd = 8'd1; end
      OP_ADDI: begin e.cycles = 8'(4 + fw); e.imm = 8'd1; e.rw = 8'd1; end
      OP_BEQ:  begin e.cycles = 8'(3 + fw); e.sub = 8'd1; e.brn = 8'd1; end
      OP_J:    begin e.cycles = 8'(3 + fw); e.jmp = 8'd1; end
`ifdef MC_CTRL_EXC_EN
      default: begin e.cycles = 8'(3 + fw); e.excs = 8'd1; end
`else
      default: begin e.cycles = 8'(2 + fw); end
`endif
    endcase
    return e;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_R;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
  endtask

  // Plays memory for one instruction starting in FETCH; returns when the next FETCH begins.
  task automatic run_instr(input logic [5:0] op, input logic zv, input int fw, input int mw,
                           output stats_t st);
    int fpend, mpend, cyc;
    bit seen, done;
    fpend = fw; mpend = mw; cyc = 0; seen = 0; done = 0; st = '0;
    while (!done && cyc < 64) begin
      opcode = op;
      zero = zv;
      if (!seen) begin
        if (fpend > 0) begin mem_ready = 1'b0; fpend--; end
        else mem_ready = 1'b1;
      end else if (mem_read || mem_write) begin
        if (mpend > 0) begin mem_ready = 1'b0; mpend--; end
        else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (mem_read && !iord && !alu_src_a && alu_src_b == 2'd1 && alu_op == 2'd0 && pc_source == 2'd0) st.fetch += 8'd1;
      if (ir_write && pc_write && pc_source == 2'd0) st.pcinc += 8'd1;
      if (!alu_src_a && alu_src_b == 2'd3 && alu_op == 2'd0) st.dec += 8'd1;
      if (alu_src_a && alu_src_b == 2'd2 && alu_op == 2'd0) st.imm += 8'd1;
      if (alu_src_a && alu_src_b == 2'd0 && alu_op == 2'd2) st.funct += 8'd1;
      if (alu_src_a && alu_src_b == 2'd0 && alu_op == 2'd1) st.sub += 8'd1;
      if (reg_write) st.rw += 8'd1;
      if (reg_write && mem_to_reg && !reg_dst) st.rw_mdr += 8'd1;
      if (reg_write && reg_dst && !mem_to_reg) st.rw_rd += 8'd1;
      if (mem_read && iord) st.mrd += 8'd1;
      if (mem_write && iord) st.mwr += 8'd1;
      if (pc_write_cond && pc_source == 2'd1) st.brn += 8'd1;
      if (pc_write && pc_source == 2'd2) st.jmp += 8'd1;
      if (exc && pc_write && pc_source == 2'd3) st.excs += 8'd1;
      if (mem_read && mem_write) st.both += 8'd1;
      if (ir_write) seen = 1;
      cyc++;
      @(negedge clk);
      if (seen && mem_read && !iord) done = 1;
    end
    st.cycles = 8'(cyc);
  endtask

  task automatic test_reset();
    logic [16:0] outs;
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h3F; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      outs = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
              alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, exc};
      n_checks++;
      if (outs !== 17'd0 || retired !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs cycle %0d got ctrl=%h retired=%0d want 0", i, outs, retired);
      end
    end
    rst = 1'b0; exp_ret = 0; #1;
    n_checks++;
    if (mem_read !== 1'b1 || iord !== 1'b0 || retired !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_to_fetch got mem_read=%b iord=%b retired=%0d want 1 0 0", mem_read, iord, retired);
    end
  endtask

  task automatic test_rtype();
    stats_t st, ex;
    reset_dut();
    run_instr(OP_R, 1'b0, 0, 0, st);
    ex = expect_stats(OP_R, 0, 0); exp_ret += retire_of(OP_R);
    n_checks++;
    if (st !== ex) begin n_fail++; $display("[TB] FAIL rtype_stats got=%h want=%h", st, ex); end
    n_checks++;
    if (retired !== RW'(exp_ret)) begin n_fail++; $display("[TB] FAIL rtype_retired got=%0d want=%0d", retired, RW'(exp_ret)); end
  endtask

  task automatic test_lw_wait();
    stats_t st, ex;
    run_instr(OP_LW, 1'b0, 0, 2, st);
    ex = expect_stats(OP_LW, 0, 2); exp_ret += retire_of(OP_LW);
    n_checks++;
    if (st !== ex) begin n_fail++; $display("[TB] FAIL lw_wait_stats got=%h want=%h", st, ex); end
    n_checks++;
    if (retired !== RW'(exp_ret)) begin n_fail++; $display("[TB] FAIL lw_wait_retired got=%0d want=%0d", retired, RW'(exp_ret)); end
  endtask

  task automatic test_beq();
    stats_t st, ex;
    for (int z = 1; z >= 0; z--) begin
      run_instr(OP_BEQ, 1'(z), 0, 0, st);
      ex = expect_stats(OP_BEQ, 0, 0); exp_ret += retire_of(OP_BEQ);
      n_checks++;
      if (st !== ex) begin n_fail++; $display("[TB] FAIL beq_stats zero=%0d got=%h want=%h", z, st, ex); end
      n_checks++;
      if (retired !== RW'(exp_ret)) begin n_fail++; $display("[TB] FAIL beq_retired zero=%0d got=%0d want=%0d", z, retired, RW'(exp_ret)); end
    end
  endtask

  task automatic test_illegal();
    stats_t st, ex;
    run_instr(6'h3F, 1'b0, 1, 0, st);
    ex = expect_stats(6'h3F, 1, 0); exp_ret += retire_of(6'h3F);
    n_checks++;
    if (st !== ex) begin n_fail++; $display("[TB] FAIL illegal_stats got=%h want=%h", st, ex); end
    n_checks++;
    if (retired !== RW'(exp_ret)) begin n_fail++; $display("[TB] FAIL illegal_retired got=%0d want=%0d", retired, RW'(exp_ret)); end
  endtask

  task automatic test_timeout();
    int n;
    reset_dut();
    mem_ready = 1'b0; n = 0; #1;
    while (mem_read && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
`ifdef MC_CTRL_EXC_EN
    n_checks++;
    if (n !== 15 || exc !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_wait got=%0d exc=%b want 15 0", n, exc); end
    @(negedge clk); #1;
    n_checks++;
    if (exc !== 1'b1 || pc_source !== 2'd3 || pc_write !== 1'b1) begin
      n_fail++; $display("[TB] FAIL timeout_exc got exc=%b pc_source=%0d pc_write=%b want 1 3 1", exc, pc_source, pc_write);
    end
    @(negedge clk); #1;
    n_checks++;
    if (mem_read !== 1'b1 || iord !== 1'b0 || exc !== 1'b0 || retired !== RW'(exp_ret)) begin
      n_fail++; $display("[TB] FAIL timeout_return got mem_read=%b exc=%b retired=%0d want 1 0 %0d", mem_read, exc, retired, RW'(exp_ret));
    end
`else
    n_checks++;
    if (n !== 40 || exc !== 1'b0 || ir_write !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fetch_hold got=%0d exc=%b ir_write=%b want 40 0 0", n, exc, ir_write);
    end
`endif
    mem_ready = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    stats_t st;
    int k;
    reset_dut();
    run_instr(OP_R, 1'b0, 0, 0, st);
    opcode = OP_SW; mem_ready = 1'b1; k = 0; #1;
    while (!mem_write && k < 10) begin
      @(negedge clk); #1;
      k++;
    end
    mem_ready = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (mem_write !== 1'b1 || iord !== 1'b1 || mem_read !== 1'b0 || retired !== RW'(1)) begin
      n_fail++; $display("[TB] FAIL sw_hold got mem_write=%b iord=%b mem_read=%b retired=%0d want 1 1 0 1", mem_write, iord, mem_read, retired);
    end
    rst = 1'b1; #1;
    n_checks++;
    if (mem_write !== 1'b0 || retired !== '0) begin
      n_fail++; $display("[TB] FAIL rst_mid_write got mem_write=%b retired=%0d want 0 0", mem_write, retired);
    end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1; exp_ret = 0; #1;
    n_checks++;
    if (mem_read !== 1'b1 || iord !== 1'b0 || mem_write !== 1'b0 || retired !== '0) begin
      n_fail++; $display("[TB] FAIL rst_mid_write_restart got mem_read=%b iord=%b retired=%0d want 1 0 0", mem_read, iord, retired);
    end
  endtask

  task automatic test_random();
    stats_t st, ex;
    logic [5:0] op;
    int fw, mw;
    reset_dut();
    for (int i = 0; i < 30; i++) begin
      op = pick_op(1'b0);
      fw = int'($urandom_range(0, 3));
      mw = int'($urandom_range(0, 3));
      run_instr(op, 1'($urandom_range(0, 1)), fw, mw, st);
      ex = expect_stats(op, fw, mw); exp_ret += retire_of(op);
      n_checks++;
      if (st !== ex) begin n_fail++; $display("[TB] FAIL random_stats #%0d op=%h got=%h want=%h", i, op, st, ex); end
      n_checks++;
      if (retired !== RW'(exp_ret)) begin n_fail++; $display("[TB] FAIL random_retired #%0d got=%0d want=%0d", i, retired, RW'(exp_ret)); end
    end
  endtask

  task automatic test_wrap();
    stats_t st;
    logic [5:0] op;
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      op = pick_op(1'b1);
      run_instr(op, 1'b0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), st);
      exp_ret += retire_of(op);
      if (i >= 14) begin
        n_checks++;
        if (retired !== RW'(exp_ret % (1 << RW))) begin
          n_fail++; $display("[TB] FAIL wrap_retired after %0d got=%0d want=%0d", i + 1, retired, exp_ret % (1 << RW));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = OP_R; zero = 1'b0;
    $display("[TB] start");
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
